// File: rtl/sap_control_sequencer.sv
// Control sequencer for the SAP 8-bit datapath. A registered T-state counter walks
// fetch (T0..T2) and the opcode-specific execute steps (T3..T6). Every strobe is
// decoded combinationally from the current step, the opcode, the flags and run.
module sap_control_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ir_in,
  output logic       a_in,
  output logic       b_in,
  output logic       out_in,
  output logic       flags_in,
  output logic       sub,
  output logic [2:0] bus_sel,
  output logic [2:0] step,
  output logic       halted,
  output logic       instr_done
);

  localparam logic [2:0] BusNone = 3'd0;
  localparam logic [2:0] BusPc   = 3'd1;
  localparam logic [2:0] BusRam  = 3'd2;
  localparam logic [2:0] BusIr   = 3'd3;
  localparam logic [2:0] BusA    = 3'd4;
  localparam logic [2:0] BusAlu  = 3'd5;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} step_e;

  step_e step_q, step_d;
  logic  halted_q, halted_d;

  // Step counter and halt flag; reset clears both asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  // Strobe decode and next step; reset and HALT force every strobe low.
  always_comb begin
    mar_in     = 1'b0;
    ram_in     = 1'b0;
    ram_out    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    ir_in      = 1'b0;
    a_in       = 1'b0;
    b_in       = 1'b0;
    out_in     = 1'b0;
    flags_in   = 1'b0;
    sub        = 1'b0;
    bus_sel    = BusNone;
    instr_done = 1'b0;
    step_d     = step_q;
    halted_d   = halted_q;

    if (halted_q) begin
      step_d = T0;
    end else if (!reset) begin
      case (step_q)
        T0: begin
          if (run) begin
            bus_sel = BusPc;
            mar_in  = 1'b1;
            step_d  = T1;
          end
        end
        T1: begin
          ram_out = 1'b1;
          pc_inc  = 1'b1;
          step_d  = T2;
        end
        T2: begin
          bus_sel = BusRam;
          ir_in   = 1'b1;
          step_d  = T3;
        end
        T3: begin
          // Anything not continuing to T4 finishes here; overridden below.
          instr_done = 1'b1;
          step_d     = T0;
          case (opcode)
            4'd1, 4'd2, 4'd3, 4'd4: begin
              bus_sel    = BusIr;
              mar_in     = 1'b1;
              instr_done = 1'b0;
              step_d     = T4;
            end
            4'd5: begin
              bus_sel = BusIr;
              a_in    = 1'b1;
            end
            4'd6: begin
              bus_sel = BusIr;
              pc_load = 1'b1;
            end
            4'd7: begin
              bus_sel = BusIr;
              pc_load = flag_c;
            end
            4'd8: begin
              bus_sel = BusIr;
              pc_load = flag_z;
            end
            4'd14: begin
              bus_sel = BusA;
              out_in  = 1'b1;
            end
            4'd15: halted_d = 1'b1;
            default: ;
          endcase
        end
        T4: begin
          step_d = T0;
          case (opcode)
            4'd1, 4'd2, 4'd3: begin
              ram_out = 1'b1;
              step_d  = T5;
            end
            4'd4: begin
              bus_sel    = BusA;
              ram_in     = 1'b1;
              instr_done = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          step_d = T0;
          case (opcode)
            4'd1: begin
              bus_sel    = BusRam;
              a_in       = 1'b1;
              instr_done = 1'b1;
            end
            4'd2, 4'd3: begin
              bus_sel = BusRam;
              b_in    = 1'b1;
              step_d  = T6;
            end
            default: ;
          endcase
        end
        T6: begin
          step_d = T0;
          if (opcode == 4'd2 || opcode == 4'd3) begin
            bus_sel    = BusAlu;
            a_in       = 1'b1;
            flags_in   = 1'b1;
            sub        = (opcode == 4'd3);
            instr_done = 1'b1;
          end
        end
        default: step_d = T0;
      endcase
    end
  end

  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: a behavioural SAP datapath obeys the DUT strobes,
// and an instruction-level ISA model predicts register/RAM state and cycle counts.
module tb_sap_control_sequencer;

  logic       clock = 1'b0;
  logic       reset, run;
  logic [3:0] opcode;
  logic       flag_c, flag_z;
  logic       mar_in, ram_in, ram_out, pc_inc, pc_load, ir_in, a_in, b_in, out_in;
  logic       flags_in, sub, halted, instr_done;
  logic [2:0] bus_sel, step;

  int errors = 0;
  int checks = 0;
  int ram_in_cnt;

  always #5 clock = ~clock;

  sap_control_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .mar_in     (mar_in),
    .ram_in     (ram_in),
    .ram_out    (ram_out),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .ir_in      (ir_in),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_in     (out_in),
    .flags_in   (flags_in),
    .sub        (sub),
    .bus_sel    (bus_sel),
    .step       (step),
    .halted     (halted),
    .instr_done (instr_done)
  );

  // Datapath plant driven by the DUT strobes
  logic [7:0] ram  [16];
  logic [7:0] prog [16];
  logic [3:0] pc, mar;
  logic [7:0] mdr, ir, a, b, out_r, bus;
  logic       fc, fz, load_prog;
  logic [8:0] alu;

  always_comb begin
    alu = sub ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
    case (bus_sel)
      3'd1:    bus = {4'h0, pc};
      3'd2:    bus = mdr;
      3'd3:    bus = {4'h0, ir[3:0]};
      3'd4:    bus = a;
      3'd5:    bus = alu[7:0];
      default: bus = 8'h00;
    endcase
  end

  assign opcode = ir[7:4];
  assign flag_c = fc;
  assign flag_z = fz;

  always @(posedge clock) begin
    if (load_prog) begin
      for (int i = 0; i < 16; i++) ram[i] <= prog[i];
      pc <= 4'h0; mar <= 4'h0; mdr <= 8'h00; ir <= 8'h00;
      a <= 8'h00; b <= 8'h00; out_r <= 8'h00; fc <= 1'b0; fz <= 1'b0;
    end else begin
      if (mar_in)  mar <= bus[3:0];
      if (ram_out) mdr <= ram[mar];
      if (ram_in)  ram[mar] <= bus;
      if (pc_load) pc <= bus[3:0];
      else if (pc_inc) pc <= pc + 4'd1;
      if (ir_in)  ir <= bus;
      if (a_in)   a <= bus;
      if (b_in)   b <= bus;
      if (out_in) out_r <= bus;
      if (flags_in) begin
        fc <= alu[8];
        fz <= (alu[7:0] == 8'h00);
      end
    end
  end

  // ISA-level reference model
  logic [7:0] m_ram [16];
  logic [3:0] m_pc;
  logic [7:0] m_a, m_out;
  logic       m_c, m_z, m_halt;

  function automatic int cycles_of(input logic [3:0] op);
    case (op)
      4'd1:       return 6;
      4'd2, 4'd3: return 7;
      4'd4:       return 5;
      default:    return 4;
    endcase
  endfunction

  task automatic model_exec();
    logic [7:0] ins;
    logic [3:0] opnd;
    logic [8:0] r;
    ins  = m_ram[m_pc];
    opnd = ins[3:0];
    m_pc = m_pc + 4'd1;
    case (ins[7:4])
      4'd1: m_a = m_ram[opnd];
      4'd2, 4'd3: begin
        if (ins[7:4] == 4'd2) r = {1'b0, m_a} + {1'b0, m_ram[opnd]};
        else r = {1'b0, m_a} + {1'b0, ~m_ram[opnd]} + 9'd1;
        m_a = r[7:0];
        m_c = r[8];
        m_z = (r[7:0] == 8'h00);
      end
      4'd4:  m_ram[opnd] = m_a;
      4'd5:  m_a = {4'h0, opnd};
      4'd6:  m_pc = opnd;
      4'd7:  if (m_c) m_pc = opnd;
      4'd8:  if (m_z) m_pc = opnd;
      4'd14: m_out = m_a;
      4'd15: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  function automatic logic any_strobe();
    return mar_in | ram_in | ram_out | pc_inc | pc_load | ir_in | a_in | b_in | out_in |
           flags_in | sub | instr_done | (bus_sel != 3'd0);
  endfunction

  function automatic logic load_no_driver();
    return (bus_sel == 3'd0) &&
           (mar_in | ram_in | pc_load | ir_in | a_in | b_in | out_in | flags_in);
  endfunction

  task automatic cmp_state(input string name);
    int bad;
    checks++;
    if (pc !== m_pc) begin
      errors++; $display("FAIL %s pc: got %h want %h", name, pc, m_pc);
    end
    checks++;
    if (a !== m_a) begin
      errors++; $display("FAIL %s a: got %h want %h", name, a, m_a);
    end
    checks++;
    if (out_r !== m_out) begin
      errors++; $display("FAIL %s out: got %h want %h", name, out_r, m_out);
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== m_ram[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL %s ram: %0d words differ, want 0", name, bad);
    end
  endtask

  // Holds reset, loads prog[] into plant and model; returns just after a negedge.
  task automatic start_prog();
    reset = 1'b1; run = 1'b0; load_prog = 1'b1;
    @(negedge clock);
    load_prog = 1'b0;
    for (int i = 0; i < 16; i++) m_ram[i] = prog[i];
    m_pc = 4'h0; m_a = 8'h00; m_out = 8'h00; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0;
    ram_in_cnt = 0;
  endtask

  // Releases reset with run=1 and tracks steps/state against the model.
  task automatic run_prog(input string name, input int max_instr);
    int idx, ninstr, ncyc;
    logic [3:0] op;
    bit pend;
    idx = 0; ninstr = 0; ncyc = 0; pend = 0;
    op = m_ram[m_pc][7:4];
    reset = 1'b0; run = 1'b1;
    while (!m_halt && ninstr < max_instr && ncyc < 400) begin
      #1;
      if (pend) begin
        cmp_state(name);
        pend = 0;
      end
      checks++;
      if (step !== 3'(idx)) begin
        errors++; $display("FAIL %s step: got %0d want %0d", name, step, idx);
      end
      checks++;
      if (load_no_driver() || bus_sel > 3'd5 || (ram_in && bus_sel !== 3'd4)) begin
        errors++; $display("FAIL %s bus: bus_sel=%0d with loads, want a driver", name, bus_sel);
      end
      if (ram_in) ram_in_cnt++;
      if (instr_done) begin
        checks++;
        if (idx + 1 != cycles_of(op)) begin
          errors++;
          $display("FAIL %s cycles op%0d: got %0d want %0d", name, op, idx + 1, cycles_of(op));
        end
        model_exec();
        ninstr++;
        idx = 0;
        pend = 1;
        op = m_ram[m_pc][7:4];
      end else begin
        idx++;
        if (idx > 6) begin
          errors++; $display("FAIL %s instr_done: got none by T6 want pulse", name);
          break;
        end
      end
      @(negedge clock);
      ncyc++;
    end
    #1;
    if (pend) cmp_state(name);
    if (m_halt) begin
      checks++;
      if (halted !== 1'b1) begin
        errors++; $display("FAIL %s halted: got %b want 1", name, halted);
      end
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (any_strobe() || step !== 3'd0 || halted !== 1'b1) begin
          errors++; $display("FAIL %s halt hold: strobes active or step=%0d, want idle", name, step);
        end
        @(negedge clock);
        #1;
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; load_prog = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (any_strobe() || step !== 3'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset: step=%0d halted=%b strobes=%b want all 0",
                         step, halted, any_strobe());
    end
  endtask

  task automatic test_run_hold();
    clear_prog();
    prog[0] = 8'h57;  // LDI 7
    start_prog();
    reset = 1'b0; run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (any_strobe() || step !== 3'd0 || halted !== 1'b0) begin
        errors++; $display("FAIL run_hold: step=%0d strobes=%b want 0", step, any_strobe());
      end
      @(negedge clock);
    end
  endtask

  // One-cycle run pulse in T0 executes exactly one instruction (LDI 7 from test_run_hold).
  task automatic test_run_pulse();
    run = 1'b1;
    #1;
    checks++;
    if (step !== 3'd0 || mar_in !== 1'b1 || bus_sel !== 3'd1) begin
      errors++; $display("FAIL run_pulse T0: step=%0d mar_in=%b bus_sel=%0d want 0 1 1",
                         step, mar_in, bus_sel);
    end
    @(negedge clock);
    run = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      #1;
      checks++;
      if (step !== 3'(s) || instr_done !== (s == 3)) begin
        errors++; $display("FAIL run_pulse T%0d: step=%0d done=%b", s, step, instr_done);
      end
      @(negedge clock);
    end
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if (any_strobe() || step !== 3'd0) begin
        errors++; $display("FAIL run_pulse idle: step=%0d strobes=%b want 0", step, any_strobe());
      end
      @(negedge clock);
    end
    checks++;
    if (a !== 8'h07 || pc !== 4'h1) begin
      errors++; $display("FAIL run_pulse state: a=%h pc=%h want 07 1", a, pc);
    end
  endtask

  task automatic test_programs();
    clear_prog();
    prog[0] = 8'h1E; prog[14] = 8'h2A;  // LDA 14
    start_prog();
    run_prog("lda", 1);
    checks++;
    if (a !== 8'h2A || pc !== 4'h1) begin
      errors++; $display("FAIL lda: a=%h pc=%h want 2a 1", a, pc);
    end

    clear_prog();
    prog[0] = 8'h55; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0; prog[15] = 8'h03;
    start_prog();
    run_prog("add_out", 10);
    checks++;
    if (out_r !== 8'h08) begin
      errors++; $display("FAIL add_out: out=%h want 08", out_r);
    end

    for (int v = 0; v < 2; v++) begin
      clear_prog();
      prog[0] = 8'h53; prog[1] = 8'h3F; prog[2] = 8'h88;
      prog[15] = (v == 0) ? 8'h03 : 8'h02;
      start_prog();
      run_prog("sub_jz", 3);
      checks++;
      if (pc !== ((v == 0) ? 4'h8 : 4'h3)) begin
        errors++; $display("FAIL sub_jz%0d: pc=%h want %h", v, pc, (v == 0) ? 4'h8 : 4'h3);
      end
    end

    clear_prog();
    prog[0] = 8'h59; prog[1] = 8'h4C;  // LDI 9; STA 12
    start_prog();
    run_prog("sta", 2);
    checks++;
    if (ram[12] !== 8'h09 || ram_in_cnt != 1) begin
      errors++; $display("FAIL sta: ram12=%h ram_in cycles=%0d want 09 1", ram[12], ram_in_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
      start_prog();
      run_prog("random", 25);
    end
  endtask

  // Reset in T5 of ADD: strobes drop at once, A keeps the LDI value, fetch resumes at PC.
  task automatic test_reset_mid();
    clear_prog();
    prog[0] = 8'h55; prog[1] = 8'h2F; prog[2] = 8'hF0; prog[15] = 8'h03;
    start_prog();
    reset = 1'b0; run = 1'b1;
    for (int k = 0; k < 9; k++) @(negedge clock);
    #1;
    checks++;
    if (step !== 3'd5 || b_in !== 1'b1) begin
      errors++; $display("FAIL reset_mid pre: step=%0d b_in=%b want 5 1", step, b_in);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (step !== 3'd0 || any_strobe()) begin
      errors++; $display("FAIL reset_mid drop: step=%0d strobes=%b want 0", step, any_strobe());
    end
    @(negedge clock);
    checks++;
    if (a !== 8'h05 || pc !== 4'h2) begin
      errors++; $display("FAIL reset_mid regs: a=%h pc=%h want 05 2", a, pc);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (step !== 3'd0 || bus_sel !== 3'd1 || bus !== 8'h02) begin
      errors++; $display("FAIL reset_mid fetch: step=%0d bus=%h want 0 02", step, bus);
    end
    for (int k = 0; k < 4; k++) @(negedge clock);
    #1;
    checks++;
    if (halted !== 1'b1 || ir !== 8'hF0) begin
      errors++; $display("FAIL reset_mid halt: halted=%b ir=%h want 1 f0", halted, ir);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; load_prog = 1'b0; ram_in_cnt = 0;
    test_reset();
    test_run_hold();
    test_run_pulse();
    test_programs();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
